// File: rtl/isa_decode_stage.sv
// isa_decode_stage: registers one decoded instruction, accepted over valid/ready.
// The decode is held until a debounced commit button retires it with a one-cycle wr_en strobe.
// Optional macro ISA_DEC_ILLEGAL_EN: flags opcodes >= NUM_OPS as illegal,
// suppresses their enables, and retires them without asserting wr_en.
module isa_decode_stage #(
  parameter int              INSTR_W   = 16,
  parameter int              OP_W      = 4,
  parameter int              REG_AW    = 4,
  parameter int              IMM_W     = 8,
  parameter logic [OP_W-1:0] LD_OPCODE = OP_W'(1),
  parameter int              DB_CYCLES = 4,
  parameter int              NUM_OPS   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               btn,
  output logic               out_valid,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_AW-1:0]  rd_addr,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [IMM_W-1:0]   imm,
  output logic               rd_en,
  output logic               rs_en,
  output logic               imm_en,
  output logic               wr_en,
  output logic               illegal
);

  localparam int              CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DB_CYCLES - 1);

  // Reject parameter sets whose fields cannot fit in the instruction word
  if (INSTR_W < OP_W + REG_AW + IMM_W || IMM_W < 2 * REG_AW ||
      DB_CYCLES < 1 || NUM_OPS < 1) begin : g_bad_params
    $error("isa_decode_stage: inconsistent parameter set");
  end

  logic             sync_meta;
  logic             sync_level;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  logic [OP_W-1:0]   dec_opcode;
  logic [REG_AW-1:0] dec_rd;
  logic [REG_AW-1:0] dec_rs;
  logic [IMM_W-1:0]  dec_imm;
  logic              dec_ld;
  logic              dec_illegal;

  logic [OP_W-1:0]   held_opcode;
  logic [REG_AW-1:0] held_rd;
  logic [REG_AW-1:0] held_rs;
  logic [IMM_W-1:0]  held_imm;
  logic              held_ld;
  logic              held_valid;
  logic              held_illegal;
  logic              retire_q;
  logic              wr_q;
  logic              load;

  // Synchronise the raw button, then count how long it has stayed high (saturating)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_meta  <= btn;
      sync_level <= sync_meta;
      if (!sync_level) begin
        db_cnt <= '0;
      end else if (db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A press fires once, on the edge where the counter steps onto its saturation value
  assign press = sync_level && (db_cnt == CNT_ARM);

  // Field extraction; the destination field moves depending on whether this is a load-immediate
  always_comb begin
    dec_opcode = instr[INSTR_W-1 -: OP_W];
    dec_ld     = (dec_opcode == LD_OPCODE);
    dec_rs     = instr[REG_AW-1:0];
    dec_imm    = instr[IMM_W-1:0];
    if (dec_ld) begin
      dec_rd = instr[INSTR_W-OP_W-1 -: REG_AW];
    end else begin
      dec_rd = instr[2*REG_AW-1:REG_AW];
    end
  end

`ifdef ISA_DEC_ILLEGAL_EN
  assign dec_illegal = (32'(dec_opcode) >= 32'(NUM_OPS));
`else
  assign dec_illegal = 1'b0;
`endif

  // The slot frees up during the commit strobe so a new instruction can land at its end
  assign instr_ready = !held_valid || wr_q;
  assign load        = instr_valid && instr_ready;

  // Holding register for the decode, plus the one-cycle retire/commit strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      held_opcode  <= '0;
      held_rd      <= '0;
      held_rs      <= '0;
      held_imm     <= '0;
      held_ld      <= 1'b0;
      held_illegal <= 1'b0;
      held_valid   <= 1'b0;
      retire_q     <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      retire_q <= press && held_valid;
      wr_q     <= press && held_valid && !held_illegal;
      if (load) begin
        held_opcode  <= dec_opcode;
        held_rd      <= dec_rd;
        held_rs      <= dec_rs;
        held_imm     <= dec_imm;
        held_ld      <= dec_ld;
        held_illegal <= dec_illegal;
        held_valid   <= 1'b1;
      end else if (retire_q) begin
        held_valid <= 1'b0;
      end
    end
  end

  assign out_valid = held_valid;
  assign opcode    = held_opcode;
  assign rd_addr   = held_rd;
  assign rs_addr   = held_rs;
  assign imm       = held_imm;
  assign wr_en     = wr_q;
  assign illegal   = held_illegal;
  assign rd_en     = held_valid && !held_illegal;
  assign imm_en    = rd_en && held_ld;
  assign rs_en     = rd_en && !held_ld;

endmodule

// File: tb/tb_isa_decode_stage.sv
// tb_isa_decode_stage: directed and randomized checks of isa_decode_stage with default widths.
// Define ISA_DEC_ILLEGAL_EN to exercise the illegal-opcode build with NUM_OPS=8.
module tb_isa_decode_stage;

  localparam int DB = 4;
`ifdef ISA_DEC_ILLEGAL_EN
  localparam int NOPS   = 8;
  localparam bit ILL_EN = 1'b1;
`else
  localparam int NOPS   = 16;
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        btn;
  logic        out_valid;
  logic [3:0]  opcode;
  logic [3:0]  rd_addr;
  logic [3:0]  rs_addr;
  logic [7:0]  imm;
  logic        rd_en;
  logic        rs_en;
  logic        imm_en;
  logic        wr_en;
  logic        illegal;

  int n_checks  = 0;
  int n_fail    = 0;
  int wr_pulses = 0;

  isa_decode_stage #(
    .INSTR_W(16), .OP_W(4), .REG_AW(4), .IMM_W(8),
    .LD_OPCODE(4'b0001), .DB_CYCLES(DB), .NUM_OPS(NOPS)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .btn(btn), .out_valid(out_valid),
    .opcode(opcode), .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm),
    .rd_en(rd_en), .rs_en(rs_en), .imm_en(imm_en), .wr_en(wr_en),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference state: what the stage should be holding, worked out from the behaviour rules
  bit m_live = 1'b0;
  bit m_valid, m_wr, m_ret, m_ill, m_ld;
  int m_op, m_rd, m_rs, m_imm;
  int m_run, m_h1, m_h2;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] i, input logic v, input logic b, input logic r);
    instr       = i;
    instr_valid = v;
    btn         = b;
    rst         = r;
    @(negedge clk);
  endtask

  task automatic press_btn();
    for (int k = 0; k < 8; k++) apply_stimulus(16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) apply_stimulus(16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance the reference model at every rising edge from the inputs alone
  always @(posedge clk) begin : model
    bit ev, rdy, ld, cm;
    int w;
    if (rst) begin
      m_live = 1'b1;
      m_valid = 0; m_wr = 0; m_ret = 0; m_ill = 0; m_ld = 0;
      m_op = 0; m_rd = 0; m_rs = 0; m_imm = 0;
      m_run = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      // The button must have been seen high DB times in a row, two samples ago
      ev  = (m_h2 == DB);
      rdy = !m_valid || m_wr;
      ld  = instr_valid && rdy;
      cm  = ev && m_valid;
      m_h2  = m_h1;
      m_run = btn ? ((m_run > DB) ? m_run : m_run + 1) : 0;
      m_h1  = m_run;
      if (ld) m_valid = 1'b1;
      else if (m_ret) m_valid = 1'b0;
      m_ret = cm;
      m_wr  = cm && !m_ill;
      if (ld) begin
        w     = int'(instr);
        m_op  = w / 4096;
        m_ld  = (m_op == 1);
        m_rd  = m_ld ? (w / 256) % 16 : (w / 16) % 16;
        m_rs  = w % 16;
        m_imm = w % 256;
        m_ill = ILL_EN && (m_op >= NOPS);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin : compare
    bit e_rd;
    if (m_live) begin
      e_rd = m_valid && !m_ill;
      check_output("out_valid", 32'(out_valid), 32'(m_valid));
      check_output("instr_ready", 32'(instr_ready), 32'(!m_valid || m_wr));
      check_output("wr_en", 32'(wr_en), 32'(m_wr));
      check_output("opcode", 32'(opcode), 32'(m_op));
      check_output("rd_addr", 32'(rd_addr), 32'(m_rd));
      check_output("rs_addr", 32'(rs_addr), 32'(m_rs));
      check_output("imm", 32'(imm), 32'(m_imm));
      check_output("rd_en", 32'(rd_en), 32'(e_rd));
      check_output("imm_en", 32'(imm_en), 32'(e_rd && m_ld));
      check_output("rs_en", 32'(rs_en), 32'(e_rd && !m_ld));
      check_output("illegal", 32'(illegal), 32'(m_ill));
      if (wr_en === 1'b1) wr_pulses++;
    end
  end

  // Directed scenarios followed by a randomized soak with a mid-run reset
  initial begin : stim
    int start, pulse_at;
    bit found, lvl;
    logic [15:0] rnd;
    logic [6:0]  glitch;

    instr = 16'h0; instr_valid = 1'b0; btn = 1'b0; rst = 1'b1;
    apply_stimulus(16'h0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(16'h0, 1'b0, 1'b0, 1'b1);
    check_output("rst_ready", 32'(instr_ready), 32'd1);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_wr", 32'(wr_en), 32'd0);
    check_output("rst_opcode", 32'(opcode), 32'd0);
    check_output("rst_rd_en", 32'(rd_en), 32'd0);

    apply_stimulus(16'h1A5C, 1'b1, 1'b0, 1'b0);
    check_output("ld_opcode", 32'(opcode), 32'h1);
    check_output("ld_rd", 32'(rd_addr), 32'hA);
    check_output("ld_imm", 32'(imm), 32'h5C);
    check_output("ld_imm_en", 32'(imm_en), 32'd1);
    check_output("ld_rs_en", 32'(rs_en), 32'd0);
    check_output("ld_rd_en", 32'(rd_en), 32'd1);
    check_output("ld_ready", 32'(instr_ready), 32'd0);
    apply_stimulus(16'h0, 1'b0, 1'b0, 1'b0);
    press_btn();
    check_output("ld_retired", 32'(out_valid), 32'd0);

    apply_stimulus(16'h2345, 1'b1, 1'b0, 1'b0);
    check_output("alu_rd", 32'(rd_addr), 32'h4);
    check_output("alu_rs", 32'(rs_addr), 32'h5);
    check_output("alu_rs_en", 32'(rs_en), 32'd1);
    start = wr_pulses;
    pulse_at = -1;
    for (int k = 1; k <= 20; k++) begin
      apply_stimulus(16'h0, 1'b0, 1'b1, 1'b0);
      if (wr_en === 1'b1 && pulse_at < 0) pulse_at = k;
    end
    for (int k = 0; k < 6; k++) apply_stimulus(16'h0, 1'b0, 1'b0, 1'b0);
    check_output("hold_pulses", 32'(wr_pulses - start), 32'd1);
    check_output("hold_latency", 32'(pulse_at), 32'd6);
    check_output("hold_retired", 32'(out_valid), 32'd0);

    apply_stimulus(16'h2345, 1'b1, 1'b0, 1'b0);
    start  = wr_pulses;
    glitch = 7'b1110111;
    for (int k = 6; k >= 0; k--) apply_stimulus(16'h0, 1'b0, glitch[k], 1'b0);
    for (int k = 0; k < 8; k++) apply_stimulus(16'h0, 1'b0, 1'b0, 1'b0);
    check_output("glitch_pulses", 32'(wr_pulses - start), 32'd0);
    check_output("glitch_held", 32'(out_valid), 32'd1);
    press_btn();
    check_output("glitch_retired", 32'(out_valid), 32'd0);

    apply_stimulus(16'h2345, 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      apply_stimulus(16'h3012, 1'b1, 1'b1, 1'b0);
      if (wr_en === 1'b1) found = 1'b1;
    end
    check_output("sim_wr_seen", 32'(found), 32'd1);
    if (found) begin
      check_output("sim_retiring_op", 32'(opcode), 32'h2);
      apply_stimulus(16'h3012, 1'b1, 1'b1, 1'b0);
      check_output("sim_valid", 32'(out_valid), 32'd1);
      check_output("sim_wr", 32'(wr_en), 32'd0);
      check_output("sim_opcode", 32'(opcode), 32'h3);
      check_output("sim_rd", 32'(rd_addr), 32'h1);
      check_output("sim_rs", 32'(rs_addr), 32'h2);
    end
    for (int k = 0; k < 6; k++) apply_stimulus(16'h0, 1'b0, 1'b0, 1'b0);
    press_btn();

`ifdef ISA_DEC_ILLEGAL_EN
    apply_stimulus(16'hF000, 1'b1, 1'b0, 1'b0);
    check_output("ill_flag", 32'(illegal), 32'd1);
    check_output("ill_rd_en", 32'(rd_en), 32'd0);
    check_output("ill_rs_en", 32'(rs_en), 32'd0);
    check_output("ill_valid", 32'(out_valid), 32'd1);
    start = wr_pulses;
    press_btn();
    check_output("ill_pulses", 32'(wr_pulses - start), 32'd0);
    check_output("ill_retired", 32'(out_valid), 32'd0);
`endif

    lvl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) lvl = !lvl;
      rnd = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rnd[15:12] = 4'h1;
      apply_stimulus(rnd, 1'($urandom_range(0, 1)), lvl, (i >= 400 && i < 402));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
